mem_sync_responder: RTL

MEM_SYNC_RESPONDER -- requirements
Module: mem_sync_responder

---
 rtl/mem_sync_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mem_sync_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_sync_pkg.sv
`default_nettype none
// ============================================================================
// mem_sync_pkg : FSM state encoding and bank-geometry helpers for mem_sync_responder
// Revision     : 1.0
// ============================================================================
package mem_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_WB    = 3'd2,
    ST_FILL  = 3'd3,
    ST_SYNC  = 3'd4
  } state_e;

  function automatic int bank_width(input int bgw, input int baw);
    return bgw + baw;
  endfunction

  function automatic int bank_count(input int bgw, input int baw);
    return 1 << (bgw + baw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : picks the lowest requesting index at or above ptr, wrapping
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int NB = 16,
  parameter int BW = 4
) (
  input  logic [NB-1:0] req_i,
  input  logic [BW-1:0] ptr_i,
  output logic [BW-1:0] gnt_o,
  output logic          gnt_valid_o
);

  logic [BW-1:0] idx;

  // NB is a power of two, so BW-bit addition wraps the search for free.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    idx         = '0;
    for (int k = 0; k < NB; k++) begin
      idx = ptr_i + BW'(k);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o       = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_sync_responder.sv
`default_nettype none
// ============================================================================
// mem_sync_responder : serves per-bank row-miss requests with optional writeback
// Revision           : 1.0
// ============================================================================
module mem_sync_responder
  import mem_sync_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int ROWBEATS  = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [bank_count(BGWIDTH, BAWIDTH)-1:0]             req,
  input  logic [bank_count(BGWIDTH, BAWIDTH)*ADDRWIDTH-1:0]   req_row,
  input  logic [bank_count(BGWIDTH, BAWIDTH)*CHWIDTH-1:0]     req_crow,
  input  logic [bank_count(BGWIDTH, BAWIDTH)-1:0]             req_dirty,
  output logic [bank_count(BGWIDTH, BAWIDTH)-1:0]             sync,
  output logic                                                busy,
  output logic                                                xfer_valid,
  input  logic                                                xfer_ready,
  output logic                                                xfer_wr,
  output logic [bank_width(BGWIDTH, BAWIDTH)-1:0]             xfer_bank,
  output logic [ADDRWIDTH-1:0]                                xfer_row,
  output logic [CHWIDTH-1:0]                                  xfer_crow,
  output logic [$clog2(ROWBEATS)-1:0]                         xfer_beat
);

  localparam int NB    = bank_count(BGWIDTH, BAWIDTH);
  localparam int BW    = bank_width(BGWIDTH, BAWIDTH);
  localparam int BEATW = $clog2(ROWBEATS);
  localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(ROWBEATS - 1);

  state_e               state_q, state_d;
  logic [BW-1:0]        bank_q, bank_d;
  logic [ADDRWIDTH-1:0] row_q, row_d;
  logic [CHWIDTH-1:0]   crow_q, crow_d;
  logic [BW-1:0]        ptr_q, ptr_d;
  logic [NB-1:0]        mask_q, mask_d;
  logic [BEATW-1:0]     beat_q, beat_d;

  logic [ADDRWIDTH-1:0] row_arr  [NB];
  logic [CHWIDTH-1:0]   crow_arr [NB];
  logic [BW-1:0]        gnt;
  logic                 gnt_valid;
  logic [NB-1:0]        bank_onehot;
  logic                 fire;

  for (genvar g = 0; g < NB; g++) begin : g_unpack
    assign row_arr[g]  = req_row[g*ADDRWIDTH +: ADDRWIDTH];
    assign crow_arr[g] = req_crow[g*CHWIDTH +: CHWIDTH];
  end

  rr_arbiter #(
    .NB (NB),
    .BW (BW)
  ) u_arb (
    .req_i       (req & ~mask_q),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid)
  );

  assign bank_onehot = NB'(1) << bank_q;
  assign xfer_valid  = (state_q == ST_WB) || (state_q == ST_FILL);
  assign xfer_wr     = (state_q == ST_WB);
  assign busy        = (state_q != ST_IDLE);
  assign sync        = (state_q == ST_SYNC) ? bank_onehot : '0;
  assign fire        = xfer_valid && xfer_ready;
  assign xfer_bank   = bank_q;
  assign xfer_row    = row_q;
  assign xfer_crow   = crow_q;
  assign xfer_beat   = beat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      crow_q  <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      crow_q  <= crow_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    crow_d  = crow_q;
    ptr_d   = ptr_q;
    mask_d  = '0;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          bank_d  = gnt;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Row, slot and dirty flag are captured here; later input changes are ignored.
        row_d   = row_arr[bank_q];
        crow_d  = crow_arr[bank_q];
        ptr_d   = bank_q + 1'b1;
        beat_d  = '0;
        state_d = req_dirty[bank_q] ? ST_WB : ST_FILL;
      end
      ST_WB, ST_FILL: begin
        if (fire) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = (state_q == ST_WB) ? ST_FILL : ST_SYNC;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_SYNC: begin
        // Hide the served bank for one IDLE cycle while its requester drops req.
        mask_d  = bank_onehot;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
